// File: rtl/grant_burst_ctrl_if.sv
// -----------------------------------------------------------------------------
// grant_burst_ctrl_if
// Shared output channel between grant_burst_ctrl and the downstream sink.
// Beats move on the valid/ready handshake: a beat is taken in a cycle where
// out_valid and out_ready are both high.
//   out_valid  : beat valid (driven by master)
//   out_ready  : sink accepts beat (driven by slave)
//   out_data   : beat payload, DW bits (driven by master)
//   out_src    : index of the requester owning the burst (driven by master)
//   out_last   : final beat of the burst (driven by master)
// Modports: master = burst controller, slave = sink.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface grant_burst_ctrl_if #(
    parameter int DW = 8
);
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_src;
    logic          out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_src,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_src,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/grant_burst_ctrl.sv
// -----------------------------------------------------------------------------
// grant_burst_ctrl
// Consumes the registered one-hot grant of a 4-way arbiter, latches the
// winning requester, streams that requester's burst onto the shared output
// channel, then pulses done[owner] for one cycle. Grants are only looked at
// in IDLE; while a burst is in flight (BURST/DONE) the owner and length are
// frozen.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   grant      one-hot grant from arbiter (lowest set bit wins)
//   req_data   per-requester beat data, slice i = [i*DW +: DW]
//   req_len    per-requester burst length minus one, slice i = [i*LENW +: LENW]
//   out_ch     shared output channel (master side of grant_burst_ctrl_if)
//   done       one-cycle pulse on the owner's bit after the last beat
//   busy       high in BURST and DONE
//   grant_err  sticky "more than one grant bit set" flag
// Build option: define GRANT_CHECK_EN to include the multi-bit grant check;
// without it grant_err is tied low.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module grant_burst_ctrl #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int LENW  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      grant,
    input  logic [N_REQ*DW-1:0]   req_data,
    input  logic [N_REQ*LENW-1:0] req_len,
    grant_burst_ctrl_if.master    out_ch,
    output logic [N_REQ-1:0]      done,
    output logic                  busy,
    output logic                  grant_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [1:0]      idx_r, idx_s;
    logic [LENW-1:0] len_r, len_s;
    logic [LENW-1:0] cnt_r, cnt_s;
    logic [1:0]      grant_idx_s;

    // Priority pick of the lowest set grant bit.
    function automatic logic [1:0] lowest_idx(input logic [3:0] g);
        logic [1:0] r;
        if (g[0])      r = 2'd0;
        else if (g[1]) r = 2'd1;
        else if (g[2]) r = 2'd2;
        else           r = 2'd3;
        return r;
    endfunction

    // Length field of requester i.
    function automatic logic [LENW-1:0] sel_len(input logic [N_REQ*LENW-1:0] v,
                                                input logic [1:0] i);
        logic [LENW-1:0] r;
        case (i)
            2'd0:    r = v[0*LENW +: LENW];
            2'd1:    r = v[1*LENW +: LENW];
            2'd2:    r = v[2*LENW +: LENW];
            2'd3:    r = v[3*LENW +: LENW];
            default: r = {LENW{1'b0}};
        endcase
        return r;
    endfunction

    // Data slice of requester i.
    function automatic logic [DW-1:0] sel_data(input logic [N_REQ*DW-1:0] v,
                                               input logic [1:0] i);
        logic [DW-1:0] r;
        case (i)
            2'd0:    r = v[0*DW +: DW];
            2'd1:    r = v[1*DW +: DW];
            2'd2:    r = v[2*DW +: DW];
            2'd3:    r = v[3*DW +: DW];
            default: r = {DW{1'b0}};
        endcase
        return r;
    endfunction

    assign grant_idx_s = lowest_idx(grant);

    // State, owner, length and beat-count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            idx_r   <= 2'd0;
            len_r   <= {LENW{1'b0}};
            cnt_r   <= {LENW{1'b0}};
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            len_r   <= len_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic and channel/status outputs decoded from registered state.
    always_comb begin
        state_s          = state_r;
        idx_s            = idx_r;
        len_s            = len_r;
        cnt_s            = cnt_r;
        out_ch.out_valid = 1'b0;
        out_ch.out_data  = {DW{1'b0}};
        out_ch.out_src   = 2'd0;
        out_ch.out_last  = 1'b0;
        done             = {N_REQ{1'b0}};
        busy             = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant != {N_REQ{1'b0}}) begin
                    idx_s   = grant_idx_s;
                    len_s   = sel_len(req_len, grant_idx_s);
                    cnt_s   = {LENW{1'b0}};
                    state_s = ST_BURST;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                busy             = 1'b1;
                out_ch.out_valid = 1'b1;
                out_ch.out_src   = idx_r;
                // Live slice: the requester holds its beat until it is taken.
                out_ch.out_data  = sel_data(req_data, idx_r);
                out_ch.out_last  = (cnt_r == len_r);
                if (out_ch.out_ready) begin
                    // cnt stops at len, so a full-width len never wraps.
                    if (cnt_r == len_r) begin
                        state_s = ST_DONE;
                    end else begin
                        cnt_s = cnt_r + {{(LENW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_s = ST_BURST;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = {{(N_REQ-1){1'b0}}, 1'b1} << idx_r;
                // Grant is deliberately not sampled here; IDLE takes it next.
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

`ifdef GRANT_CHECK_EN
    logic grant_err_r;
    logic multi_grant_s;

    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi_grant_s = ((grant & (grant - {{(N_REQ-1){1'b0}}, 1'b1})) != {N_REQ{1'b0}});

    // Sticky illegal-grant flag, only evaluated when grant is actually sampled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_err_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && multi_grant_s) begin
            grant_err_r <= 1'b1;
        end else begin
            grant_err_r <= grant_err_r;
        end
    end

    assign grant_err = grant_err_r;
`else
    assign grant_err = 1'b0;
`endif

endmodule

// File: tb/tb_grant_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_grant_burst_ctrl
// Directed bench for grant_burst_ctrl. Inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_grant_burst_ctrl;

    localparam int DW   = 8;
    localparam int LENW = 4;

`ifdef GRANT_CHECK_EN
    localparam logic GERR = 1'b1;
`else
    localparam logic GERR = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic [3:0]        grant;
    logic [4*DW-1:0]   req_data;
    logic [4*LENW-1:0] req_len;
    logic [3:0]        done;
    logic              busy;
    logic              grant_err;

    int tests_run;
    int tests_failed;
    int accepted;

    grant_burst_ctrl_if #(.DW(DW)) ch ();

    grant_burst_ctrl #(.N_REQ(4), .DW(DW), .LENW(LENW)) dut (
        .clk       (clk),
        .reset     (reset),
        .grant     (grant),
        .req_data  (req_data),
        .req_len   (req_len),
        .out_ch    (ch),
        .done      (done),
        .busy      (busy),
        .grant_err (grant_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [1:0] src,
                              input logic [7:0] data, input logic last,
                              input logic [3:0] dn, input logic bsy);
        check({tag, ".valid"}, {31'd0, ch.out_valid}, {31'd0, v});
        check({tag, ".src"},   {30'd0, ch.out_src},   {30'd0, src});
        check({tag, ".data"},  {24'd0, ch.out_data},  {24'd0, data});
        check({tag, ".last"},  {31'd0, ch.out_last},  {31'd0, last});
        check({tag, ".done"},  {28'd0, done},         {28'd0, dn});
        check({tag, ".busy"},  {31'd0, busy},         {31'd0, bsy});
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        grant        = 4'b0000;
        ch.out_ready = 1'b0;
        req_data     = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req_len      = 16'h0000;

        // Reset state
        nxt(); nxt(); #1;
        expect_out("rst", 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000, 1'b0);
        check("rst.gerr", {31'd0, grant_err}, 32'd0);
        nxt(); reset = 1'b1;

        // 1: grant 0100, len 2, ready high -> 3 beats from src 2
        nxt(); grant = 4'b0100; req_len[2*LENW +: LENW] = 4'd2; ch.out_ready = 1'b1;
        #1; expect_out("t1.idle", 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000, 1'b0);
        nxt(); grant = 4'b0000; #1;
        expect_out("t1.b0", 1'b1, 2'd2, 8'hC2, 1'b0, 4'b0000, 1'b1);
        nxt(); req_data[2*DW +: DW] = 8'h55; #1;
        expect_out("t1.b1", 1'b1, 2'd2, 8'h55, 1'b0, 4'b0000, 1'b1);
        nxt(); #1;
        expect_out("t1.b2", 1'b1, 2'd2, 8'h55, 1'b1, 4'b0000, 1'b1);
        nxt(); #1;
        expect_out("t1.done", 1'b0, 2'd0, 8'h00, 1'b0, 4'b0100, 1'b1);
        nxt(); #1;
        expect_out("t1.end", 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000, 1'b0);

        // 2: grant 0001, len 0, ready low for 3 valid cycles then high
        grant = 4'b0001; ch.out_ready = 1'b0;
        nxt(); grant = 4'b0000; #1;
        expect_out("t2.w0", 1'b1, 2'd0, 8'hA0, 1'b1, 4'b0000, 1'b1);
        nxt(); #1;
        expect_out("t2.w1", 1'b1, 2'd0, 8'hA0, 1'b1, 4'b0000, 1'b1);
        nxt(); #1;
        expect_out("t2.w2", 1'b1, 2'd0, 8'hA0, 1'b1, 4'b0000, 1'b1);
        nxt(); ch.out_ready = 1'b1; #1;
        expect_out("t2.beat", 1'b1, 2'd0, 8'hA0, 1'b1, 4'b0000, 1'b1);
        nxt(); #1;
        expect_out("t2.done", 1'b0, 2'd0, 8'h00, 1'b0, 4'b0001, 1'b1);
        nxt(); #1;
        expect_out("t2.end", 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000, 1'b0);

        // 3: grant 0010 (len 1) then 1000 mid-burst; src 3 served after IDLE
        grant = 4'b0010; req_len[1*LENW +: LENW] = 4'd1; req_len[3*LENW +: LENW] = 4'd0;
        nxt(); grant = 4'b1000; #1;
        expect_out("t3.b0", 1'b1, 2'd1, 8'hB1, 1'b0, 4'b0000, 1'b1);
        nxt(); #1;
        expect_out("t3.b1", 1'b1, 2'd1, 8'hB1, 1'b1, 4'b0000, 1'b1);
        nxt(); #1;
        expect_out("t3.done", 1'b0, 2'd0, 8'h00, 1'b0, 4'b0010, 1'b1);
        nxt(); #1;
        expect_out("t3.idle", 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000, 1'b0);
        nxt(); grant = 4'b0000; #1;
        expect_out("t3.s3b0", 1'b1, 2'd3, 8'hD3, 1'b1, 4'b0000, 1'b1);
        nxt(); #1;
        expect_out("t3.s3done", 1'b0, 2'd0, 8'h00, 1'b0, 4'b1000, 1'b1);

        // 4: len 15, ready toggling -> 16 accepted beats, last only on 16th
        nxt(); grant = 4'b0001; req_len[0 +: LENW] = 4'd15; ch.out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 40 && accepted < 16; i++) begin
            nxt(); grant = 4'b0000; ch.out_ready = (i % 2) == 1; #1;
            check($sformatf("t4.valid%0d", i), {31'd0, ch.out_valid}, 32'd1);
            check($sformatf("t4.last%0d", i), {31'd0, ch.out_last}, (accepted == 15) ? 32'd1 : 32'd0);
            if (ch.out_ready) accepted++;
        end
        nxt(); #1;
        expect_out("t4.done", 1'b0, 2'd0, 8'h00, 1'b0, 4'b0001, 1'b1);
        nxt(); #1;
        expect_out("t4.end", 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000, 1'b0);

        // 5: reset during beat 2 of 4, then a fresh 2-beat burst from src 0
        grant = 4'b0100; req_len[2*LENW +: LENW] = 4'd3; ch.out_ready = 1'b1;
        nxt(); grant = 4'b0000; #1;
        expect_out("t5.b0", 1'b1, 2'd2, 8'h55, 1'b0, 4'b0000, 1'b1);
        nxt(); #1;
        expect_out("t5.b1", 1'b1, 2'd2, 8'h55, 1'b0, 4'b0000, 1'b1);
        reset = 1'b0; #1;
        expect_out("t5.rst", 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000, 1'b0);
        nxt(); reset = 1'b1;
        nxt(); #1;
        expect_out("t5.idle", 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000, 1'b0);
        grant = 4'b0001; req_len[0 +: LENW] = 4'd1;
        nxt(); grant = 4'b0000; #1;
        expect_out("t5.n0", 1'b1, 2'd0, 8'hA0, 1'b0, 4'b0000, 1'b1);
        nxt(); #1;
        expect_out("t5.n1", 1'b1, 2'd0, 8'hA0, 1'b1, 4'b0000, 1'b1);
        nxt(); #1;
        expect_out("t5.done", 1'b0, 2'd0, 8'h00, 1'b0, 4'b0001, 1'b1);

        // 6: multi-bit grant 0110 -> burst from src 1, grant_err per build
        nxt(); grant = 4'b0110; req_len[1*LENW +: LENW] = 4'd0; #1;
        check("t6.gerr0", {31'd0, grant_err}, 32'd0);
        nxt(); grant = 4'b0000; #1;
        expect_out("t6.b0", 1'b1, 2'd1, 8'hB1, 1'b1, 4'b0000, 1'b1);
        check("t6.gerr1", {31'd0, grant_err}, {31'd0, GERR});
        nxt(); #1;
        expect_out("t6.done", 1'b0, 2'd0, 8'h00, 1'b0, 4'b0010, 1'b1);
        nxt(); nxt(); #1;
        check("t6.sticky", {31'd0, grant_err}, {31'd0, GERR});
        reset = 1'b0; #1;
        check("t6.clr", {31'd0, grant_err}, 32'd0);
        nxt(); reset = 1'b1;
        nxt();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
